fptr_pool_mgr: RTL and testbench

FPTR_POOL_MGR -- requirements
Module: fptr_pool_mgr

---
 rtl/fptr_pool_mgr.sv | 142 ++++++++++++++
 tb/tb_fptr_pool_mgr.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fptr_pool_mgr.sv
// Free-pointer pool: circular buffer of PTR_NUM pointers, filled at start-up, handed out FIFO.
// Optional double-free detection bitmap enabled by macro FPTR_DBL_FREE_CHK_EN.
module fptr_pool_mgr #(
  parameter int PTR_WID  = 9,
  parameter int PTR_NUM  = 512,
  parameter int PTR_BASE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alloc_req,
  output logic               alloc_ack,
  output logic [PTR_WID-1:0] alloc_ptr,
  input  logic               free_wen,
  input  logic [PTR_WID-1:0] free_ptr,
  output logic [PTR_WID:0]   free_cnt,
  output logic               init_done,
  output logic               err_underflow,
  output logic               err_overflow,
  output logic               err_range,
  output logic               err_dbl_free
);

  typedef enum logic [1:0] {S_RESET, S_INIT, S_RUN} state_t;

  localparam logic [PTR_WID-1:0] LAST_IDX = PTR_WID'(PTR_NUM - 1);
  localparam logic [PTR_WID-1:0] BASE     = PTR_WID'(PTR_BASE);
  localparam logic [PTR_WID:0]   BASE_X   = (PTR_WID+1)'(PTR_BASE);
  localparam logic [PTR_WID:0]   FULL_CNT = (PTR_WID+1)'(PTR_NUM);

  state_t             state, next;
  logic [PTR_WID-1:0] mem [PTR_NUM];
  logic [PTR_WID-1:0] rd_idx, wr_idx;
  logic [PTR_WID:0]   free_rel;
  logic               init_wr, alloc_ok, free_ok, uflow, range_bad, ovf_bad, init_ovf, dbl_hit;

  function automatic logic [PTR_WID-1:0] wrap_inc(input logic [PTR_WID-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // Pointers below PTR_BASE wrap to a huge offset, so one compare covers both bounds
  assign free_rel = {1'b0, free_ptr} - BASE_X;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_RESET;
    else        state <= next;
  end

  // The cycle that leaves RESET already performs the first fill write
  always_comb begin
    next = state;
    case (state)
      S_RESET, S_INIT: next = (wr_idx == LAST_IDX) ? S_RUN : S_INIT;
      S_RUN:           next = S_RUN;
      default:         next = S_RESET;
    endcase
  end

  always_comb begin
    init_wr   = 1'b0;
    alloc_ok  = 1'b0;
    uflow     = 1'b0;
    range_bad = 1'b0;
    ovf_bad   = 1'b0;
    free_ok   = 1'b0;
    init_ovf  = 1'b0;
    init_done = 1'b0;
    case (state)
      S_RESET, S_INIT: begin
        init_wr  = 1'b1;
        init_ovf = free_wen;
      end
      S_RUN: begin
        init_done = 1'b1;
        alloc_ok  = alloc_req && (free_cnt != '0);
        uflow     = alloc_req && (free_cnt == '0);
        range_bad = free_wen && (free_rel >= FULL_CNT);
        ovf_bad   = free_wen && !range_bad && (free_cnt == FULL_CNT) && !alloc_ok;
        free_ok   = free_wen && !range_bad && !ovf_bad && !dbl_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alloc_ack     <= 1'b0;
      alloc_ptr     <= '0;
      free_cnt      <= '0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
      err_range     <= 1'b0;
      rd_idx        <= '0;
      wr_idx        <= '0;
    end else begin
      alloc_ack     <= alloc_ok;
      err_underflow <= uflow;
      err_overflow  <= init_ovf || ovf_bad;
      err_range     <= range_bad;
      if (alloc_ok) begin
        alloc_ptr <= mem[rd_idx];
        rd_idx    <= wrap_inc(rd_idx);
      end
      if (init_wr || free_ok) wr_idx <= wrap_inc(wr_idx);
      case ({init_wr || free_ok, alloc_ok})
        2'b10:   free_cnt <= free_cnt + 1'b1;
        2'b01:   free_cnt <= free_cnt - 1'b1;
        default: free_cnt <= free_cnt;
      endcase
    end
  end

  // Pool storage carries no reset; the fill after every reset rewrites it
  always_ff @(posedge clk) begin
    if (rst_n && init_wr)      mem[wr_idx] <= BASE + wr_idx;
    else if (rst_n && free_ok) mem[wr_idx] <= free_ptr;
  end

`ifdef FPTR_DBL_FREE_CHK_EN
  logic [PTR_NUM-1:0] bitmap;
  logic [PTR_WID-1:0] alloc_off, free_off;

  assign alloc_off = mem[rd_idx] - BASE;
  assign free_off  = free_rel[PTR_WID-1:0];
  assign dbl_hit   = free_wen && (state == S_RUN) && !range_bad && !ovf_bad && bitmap[free_off];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bitmap       <= '0;
      err_dbl_free <= 1'b0;
    end else begin
      err_dbl_free <= dbl_hit;
      if (init_wr)  bitmap[wr_idx]    <= 1'b1;
      if (alloc_ok) bitmap[alloc_off] <= 1'b0;
      if (free_ok)  bitmap[free_off]  <= 1'b1;
    end
  end
`else
  assign dbl_hit      = 1'b0;
  assign err_dbl_free = 1'b0;
`endif

endmodule

// File: tb/tb_fptr_pool_mgr.sv
// Directed bench for fptr_pool_mgr (PTR_WID=4, PTR_NUM=12, PTR_BASE=2) with a queue-based pool model.
module tb_fptr_pool_mgr;
  localparam int W = 4;
  localparam int N = 12;
  localparam int B = 2;
`ifdef FPTR_DBL_FREE_CHK_EN
  localparam bit DBL_EN = 1'b1;
`else
  localparam bit DBL_EN = 1'b0;
`endif

  typedef struct {
    logic         ack;
    logic [W-1:0] ptr;
    logic         uf, of, rg, db;
    logic [W:0]   cnt;
  } exp_t;

  logic         clk = 1'b0, rst_n = 1'b0, alloc_req = 1'b0, free_wen = 1'b0;
  logic [W-1:0] free_ptr = '0;
  logic         alloc_ack, init_done, err_underflow, err_overflow, err_range, err_dbl_free;
  logic [W-1:0] alloc_ptr;
  logic [W:0]   free_cnt;

  exp_t         sb[$];
  logic [W-1:0] pool[$];
  logic [W-1:0] last_ptr = '0;
  logic [W-1:0] p;
  int           total = 0, bad = 0;

  fptr_pool_mgr #(.PTR_WID(W), .PTR_NUM(N), .PTR_BASE(B)) dut (
    .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_ack(alloc_ack), .alloc_ptr(alloc_ptr),
    .free_wen(free_wen), .free_ptr(free_ptr), .free_cnt(free_cnt), .init_done(init_done),
    .err_underflow(err_underflow), .err_overflow(err_overflow), .err_range(err_range),
    .err_dbl_free(err_dbl_free)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit in_pool(input logic [W-1:0] v);
    foreach (pool[i]) if (pool[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_reset();
    chk("rst_ack", 32'(alloc_ack), 0);
    chk("rst_ptr", 32'(alloc_ptr), 0);
    chk("rst_cnt", 32'(free_cnt), 0);
    chk("rst_done", 32'(init_done), 0);
    chk("rst_errs", 32'({err_underflow, err_overflow, err_range, err_dbl_free}), 0);
  endtask

  // Releases reset and walks the fill; a free/alloc in fill cycle 4 must be dropped
  task automatic do_init();
    rst_n = 1'b1;
    for (int k = 1; k <= N; k++) begin
      alloc_req = (k == 4);
      free_wen  = (k == 4);
      free_ptr  = 4'd5;
      @(posedge clk); #1;
      alloc_req = 1'b0;
      free_wen  = 1'b0;
      chk("init_cnt", 32'(free_cnt), 32'(k));
      chk("init_done", 32'(init_done), 32'(k == N));
      if (k == 4) begin
        chk("init_ovf", 32'(err_overflow), 1);
        chk("init_noack", 32'(alloc_ack), 0);
      end
    end
    pool.delete();
    for (int i = 0; i < N; i++) pool.push_back(W'(B + i));
    last_ptr = '0;
  endtask

  task automatic step(input logic a, input logic f, input logic [W-1:0] fp, output logic [W-1:0] got);
    exp_t e;
    logic aok, fok;
    alloc_req = a;
    free_wen  = f;
    free_ptr  = fp;
    aok  = a && (pool.size() > 0);
    e.uf = a && (pool.size() == 0);
    e.rg = f && ((int'(fp) < B) || (int'(fp) > B + N - 1));
    e.of = f && !e.rg && (pool.size() == N) && !aok;
    e.db = DBL_EN && f && !e.rg && !e.of && in_pool(fp);
    fok  = f && !e.rg && !e.of && !e.db;
    if (aok) last_ptr = pool.pop_front();
    if (fok) pool.push_back(fp);
    e.ack = aok;
    e.ptr = last_ptr;
    e.cnt = (W+1)'(pool.size());
    sb.push_back(e);
    @(posedge clk); #1;
    alloc_req = 1'b0;
    free_wen  = 1'b0;
    e = sb.pop_front();
    chk("ack", 32'(alloc_ack), 32'(e.ack));
    chk("ptr", 32'(alloc_ptr), 32'(e.ptr));
    chk("underflow", 32'(err_underflow), 32'(e.uf));
    chk("overflow", 32'(err_overflow), 32'(e.of));
    chk("range", 32'(err_range), 32'(e.rg));
    chk("dbl_free", 32'(err_dbl_free), 32'(e.db));
    chk("free_cnt", 32'(free_cnt), 32'(e.cnt));
    got = e.ptr;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    do_init();

    // drain in FIFO order, then one alloc too many
    for (int i = 0; i < N; i++) begin
      step(1'b1, 1'b0, '0, p);
      chk("fifo_order", 32'(p), 32'(B + i));
    end
    step(1'b1, 1'b0, '0, p);

    // out-of-range frees just below and just above the window
    step(1'b0, 1'b1, 4'd1, p);
    step(1'b0, 1'b1, 4'd14, p);
    step(1'b0, 1'b1, 4'd15, p);

    // refill completely, then exercise the full-pool corner
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, W'(B + N - 1 - i), p);
    step(1'b1, 1'b1, 4'd7, p);
    step(1'b0, 1'b1, 4'd5, p);

    // pull pointer 2 back out, then return it twice
    for (int i = 0; i < N + 1; i++) begin
      step(1'b1, 1'b0, '0, p);
      if (p == 4'd2 && alloc_ack) break;
    end
    step(1'b0, 1'b1, 4'd2, p);
    step(1'b0, 1'b1, 4'd2, p);

    // empty pool with a same-cycle free: no bypass, free still lands
    while (pool.size() > 0) step(1'b1, 1'b0, '0, p);
    step(1'b1, 1'b1, 4'd3, p);
    step(1'b1, 1'b0, '0, p);
    step(1'b0, 1'b0, '0, p);

    // reset in the middle of RUN with an alloc pending
    alloc_req = 1'b1;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    alloc_req = 1'b0;
    check_reset();
    do_init();
    step(1'b1, 1'b0, '0, p);

    // reset during the fifth fill cycle, then a full refill
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_init_cnt", 32'(free_cnt), 4);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset();
    do_init();
    step(1'b1, 1'b0, '0, p);
    step(1'b1, 1'b0, '0, p);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
